// File: rtl/ray_pkg.sv
// Shared constants for the ray column sequencer: angle units, port widths and FSM encoding.
package ray_pkg;

  localparam int DEG_FULL      = 360;
  localparam int MILLI_PER_DEG = 1000;
  localparam int POS_W         = 13;
  localparam int ANG_W         = 10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/angle_step_unit.sv
// Combinational angle decrement: subtracts STEP_MILLI thousandths with borrow into the
// integer degrees, optionally wrapping the integer from 0 back to 359.
module angle_step_unit
  import ray_pkg::*;
#(
  parameter int STEP_MILLI = 375,
  parameter bit WRAP       = 1'b1
) (
  input  logic signed [ANG_W-1:0] int_in,
  input  logic        [ANG_W-1:0] frac_in,
  output logic signed [ANG_W-1:0] int_out,
  output logic        [ANG_W-1:0] frac_out
);

  localparam logic        [ANG_W-1:0] STEP_V   = ANG_W'(STEP_MILLI);
  localparam logic        [ANG_W-1:0] REFILL_V = ANG_W'(MILLI_PER_DEG - STEP_MILLI);
  localparam logic signed [ANG_W-1:0] TOP_V    = ANG_W'(DEG_FULL - 1);
  localparam logic signed [ANG_W-1:0] ONE_V    = ANG_W'(1);

  logic borrow;

  // Fractions are unsigned 0..999; borrowing adds (1000 - step) rather than going negative.
  assign borrow   = frac_in < STEP_V;
  assign frac_out = borrow ? frac_in + REFILL_V : frac_in - STEP_V;
  assign int_out  = !borrow                   ? int_in :
                    (WRAP && int_in == '0)    ? TOP_V  :
                                                int_in - ONE_V;

endmodule

// File: rtl/ray_column_sequencer.sv
// Per-frame ray sweep: snapshots player/heading on start and emits one ray per column.
// Optional relative-angle outputs enabled by defining RAY_SWEEP_REL_ANGLE_EN.
//
//   state  | meaning
//   IDLE   | waiting for start; inputs latched when start=1
//   LOAD   | normalise heading, preset column 0 angle
//   EMIT   | ray_valid high, advance one column per accepted ray
//   DONE   | frame_done pulse, busy still high
module ray_column_sequencer
  import ray_pkg::*;
#(
  parameter int NUM_COLS     = 160,
  parameter int COL_W        = 8,
  parameter int HALF_FOV_DEG = 30,
  parameter int STEP_MILLI   = 375
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [POS_W-1:0] playerX,
  input  logic signed [POS_W-1:0] playerY,
  input  logic signed [ANG_W-1:0] angle_X,
  input  logic signed [ANG_W-1:0] angle_Y,
  input  logic                    ray_ready,
  output logic                    ray_valid,
  output logic        [COL_W-1:0] ray_col,
  output logic signed [ANG_W-1:0] ray_angle_int,
  output logic signed [ANG_W-1:0] ray_angle_frac,
  output logic signed [POS_W-1:0] ray_playerX,
  output logic signed [POS_W-1:0] ray_playerY,
  output logic signed [ANG_W-1:0] ray_rel_int,
  output logic signed [ANG_W-1:0] ray_rel_frac,
  output logic                    busy,
  output logic                    frame_done
);

  localparam logic signed [ANG_W-1:0] DEG_V  = ANG_W'(DEG_FULL);
  localparam logic signed [ANG_W-1:0] HALF_V = ANG_W'(HALF_FOV_DEG);
  localparam logic        [COL_W-1:0] LAST_C = COL_W'(NUM_COLS - 1);
  localparam logic        [COL_W-1:0] ONE_C  = COL_W'(1);

  logic [1:0]              state;
  logic signed [POS_W-1:0] lat_x, lat_y;
  logic signed [ANG_W-1:0] lat_hd_int;
  logic        [ANG_W-1:0] lat_hd_frac;
  logic        [COL_W-1:0] col;
  logic signed [ANG_W-1:0] ang_int, nxt_int;
  logic        [ANG_W-1:0] ang_frac, nxt_frac;
  logic signed [ANG_W-1:0] hd_norm, start_int;

  // Heading integer is taken as two's complement; fraction bits as unsigned 0..999.
  always_comb begin
    hd_norm = lat_hd_int;
    if (lat_hd_int[ANG_W-1])
      hd_norm = lat_hd_int + DEG_V;
    else if (lat_hd_int >= DEG_V)
      hd_norm = lat_hd_int - DEG_V;
    start_int = hd_norm + HALF_V;
    if (start_int >= DEG_V)
      start_int = start_int - DEG_V;
  end

  angle_step_unit #(.STEP_MILLI(STEP_MILLI), .WRAP(1'b1)) u_abs_step (
    .int_in  (ang_int),
    .frac_in (ang_frac),
    .int_out (nxt_int),
    .frac_out(nxt_frac)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      lat_x       <= '0;
      lat_y       <= '0;
      lat_hd_int  <= '0;
      lat_hd_frac <= '0;
      col         <= '0;
      ang_int     <= '0;
      ang_frac    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          lat_x       <= playerX;
          lat_y       <= playerY;
          lat_hd_int  <= angle_X;
          lat_hd_frac <= angle_Y;
          state       <= S_LOAD;
        end
        S_LOAD: begin
          ang_int  <= start_int;
          ang_frac <= lat_hd_frac;
          col      <= '0;
          state    <= S_EMIT;
        end
        S_EMIT: if (ray_ready) begin
          if (col == LAST_C) begin
            state <= S_DONE;
          end else begin
            col      <= col + ONE_C;
            ang_int  <= nxt_int;
            ang_frac <= nxt_frac;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RAY_SWEEP_REL_ANGLE_EN
  logic signed [ANG_W-1:0] rel_int, nxt_rel_int;
  logic        [ANG_W-1:0] rel_frac, nxt_rel_frac;

  angle_step_unit #(.STEP_MILLI(STEP_MILLI), .WRAP(1'b0)) u_rel_step (
    .int_in  (rel_int),
    .frac_in (rel_frac),
    .int_out (nxt_rel_int),
    .frac_out(nxt_rel_frac)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rel_int  <= '0;
      rel_frac <= '0;
    end else if (state == S_LOAD) begin
      rel_int  <= HALF_V;
      rel_frac <= '0;
    end else if (state == S_EMIT && ray_ready && col != LAST_C) begin
      rel_int  <= nxt_rel_int;
      rel_frac <= nxt_rel_frac;
    end
  end

  assign ray_rel_int  = rel_int;
  assign ray_rel_frac = rel_frac;
`else
  assign ray_rel_int  = '0;
  assign ray_rel_frac = '0;
`endif

  assign ray_valid      = (state == S_EMIT);
  assign busy           = (state != S_IDLE);
  assign frame_done     = (state == S_DONE);
  assign ray_col        = col;
  assign ray_angle_int  = ang_int;
  assign ray_angle_frac = ang_frac;
  assign ray_playerX    = lat_x;
  assign ray_playerY    = lat_y;

endmodule

// File: tb/tb_ray_column_sequencer.sv
// Directed bench for ray_column_sequencer: sweep angles, wrap, backpressure, restart and reset abort.
module tb_ray_column_sequencer;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic signed [12:0] playerX = '0, playerY = '0;
  logic signed [9:0]  angle_X = '0, angle_Y = '0;
  logic              ray_ready = 1'b0;
  logic              ray_valid, busy, frame_done;
  logic [7:0]        ray_col;
  logic signed [9:0] ray_angle_int, ray_angle_frac, ray_rel_int, ray_rel_frac;
  logic signed [12:0] ray_playerX, ray_playerY;

  int n_tests = 0;
  int n_fail  = 0;

  int n_xfer = 0;
  int fd_count = 0;
  int col_log [0:255];
  int int_log [0:255];
  int frac_log[0:255];
  int px_log  [0:255];
  int py_log  [0:255];
  int rint_log[0:255];
  int rfrc_log[0:255];

  ray_column_sequencer dut (
    .clock(clock), .reset(reset), .start(start),
    .playerX(playerX), .playerY(playerY), .angle_X(angle_X), .angle_Y(angle_Y),
    .ray_ready(ray_ready), .ray_valid(ray_valid), .ray_col(ray_col),
    .ray_angle_int(ray_angle_int), .ray_angle_frac(ray_angle_frac),
    .ray_playerX(ray_playerX), .ray_playerY(ray_playerY),
    .ray_rel_int(ray_rel_int), .ray_rel_frac(ray_rel_frac),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Transfer logger; clears itself while the DUT sits in LOAD.
  always @(negedge clock) begin
    if (busy && !ray_valid && !frame_done) n_xfer = 0;
    if (ray_valid && ray_ready) begin
      if (n_xfer < 256) begin
        col_log[n_xfer]  = int'(ray_col);
        int_log[n_xfer]  = int'(ray_angle_int);
        frac_log[n_xfer] = int'($unsigned(ray_angle_frac));
        px_log[n_xfer]   = int'(ray_playerX);
        py_log[n_xfer]   = int'(ray_playerY);
        rint_log[n_xfer] = int'(ray_rel_int);
        rfrc_log[n_xfer] = int'($unsigned(ray_rel_frac));
      end
      n_xfer++;
    end
    if (frame_done) fd_count++;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_frame(input int ax, input int ay, input int px, input int py);
    @(posedge clock); #1;
    angle_X = 10'(ax);
    angle_Y = 10'(ay);
    playerX = 13'(px);
    playerY = 13'(py);
    start   = 1'b1;
    @(posedge clock); #1;
    start   = 1'b0;
  endtask

  task automatic wait_frame_done(input string tag);
    int cyc = 0;
    do begin @(negedge clock); cyc++; end while (!frame_done && cyc < 2000);
    check_val({tag, "_done_seen"}, int'(frame_done), 1);
    check_val({tag, "_busy_in_done"}, int'(busy), 1);
    @(negedge clock);
    check_val({tag, "_busy_after"}, int'(busy), 0);
    check_val({tag, "_done_one_cycle"}, int'(frame_done), 0);
    #1;
  endtask

  task automatic wait_col(input string tag, input int c);
    int cyc = 0;
    do begin @(posedge clock); #1; cyc++; end
    while (!(ray_valid && int'(ray_col) == c) && cyc < 1000);
    check_val({tag, "_reach_col"}, int'(ray_col), c);
  endtask

  initial begin
    int fd0;
    logic [53:0] snap;

    // reset state
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_val("rst_valid", int'(ray_valid), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(frame_done), 0);
    check_val("rst_col", int'(ray_col), 0);
    check_val("rst_int", int'(ray_angle_int), 0);
    check_val("rst_px", int'(ray_playerX), 0);
    check_val("rst_rel", int'(ray_rel_int), 0);

    // heading 90/0, full sweep, latency
    ray_ready = 1'b1;
    fd0 = fd_count;
    start_frame(90, 0, 7, 9);
    check_val("lat_load_busy", int'(busy), 1);
    check_val("lat_load_valid", int'(ray_valid), 0);
    @(posedge clock); #1;
    check_val("lat_col0_valid", int'(ray_valid), 1);
    check_val("lat_col0_int", int'(ray_angle_int), 120);
    wait_frame_done("h90");
    check_val("h90_count", n_xfer, 160);
    check_val("h90_fd_count", fd_count - fd0, 1);
    check_val("h90_c0_int", int_log[0], 120);
    check_val("h90_c0_frac", frac_log[0], 0);
    check_val("h90_c1_int", int_log[1], 119);
    check_val("h90_c1_frac", frac_log[1], 625);
    check_val("h90_c159_col", col_log[159], 159);
    check_val("h90_c159_int", int_log[159], 60);
    check_val("h90_c159_frac", frac_log[159], 375);
    check_val("h90_px", px_log[80], 7);
`ifdef RAY_SWEEP_REL_ANGLE_EN
    check_val("h90_rel0", rint_log[0], 30);
    check_val("h90_rel1_frac", rfrc_log[1], 625);
    check_val("h90_rel159_int", rint_log[159], -30);
    check_val("h90_rel159_frac", rfrc_log[159], 375);
`else
    check_val("h90_rel_tied", rint_log[159], 0);
    check_val("h90_relf_tied", rfrc_log[1], 0);
`endif

    // heading 350/0, wrap through 0
    start_frame(350, 0, 1, 1);
    wait_frame_done("h350");
    check_val("h350_c0_int", int_log[0], 20);
    check_val("h350_c0_frac", frac_log[0], 0);
    check_val("h350_c53_int", int_log[53], 0);
    check_val("h350_c53_frac", frac_log[53], 125);
    check_val("h350_c54_int", int_log[54], 359);
    check_val("h350_c54_frac", frac_log[54], 750);
    check_val("h350_c55_int", int_log[55], 359);
    check_val("h350_c55_frac", frac_log[55], 375);

    // negative heading -10/500
    start_frame(-10, 500, 1, 1);
    wait_frame_done("hneg");
    check_val("hneg_c0_int", int_log[0], 20);
    check_val("hneg_c0_frac", frac_log[0], 500);
    check_val("hneg_c1_frac", frac_log[1], 125);

    // backpressure at column 3
    start_frame(90, 0, 3, 4);
    wait_col("bp", 3);
    ray_ready = 1'b0;
    snap = {ray_col, ray_angle_int, ray_angle_frac, ray_playerX, ray_playerY};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_val($sformatf("bp_hold%0d", i),
                int'({ray_col, ray_angle_int, ray_angle_frac, ray_playerX, ray_playerY} == snap), 1);
    end
    @(posedge clock); #1;
    ray_ready = 1'b1;
    @(posedge clock); #1;
    check_val("bp_col4", int'(ray_col), 4);
    wait_frame_done("bp");
    check_val("bp_count", n_xfer, 160);
    check_val("bp_c3_frac", frac_log[3], 875);
    check_val("bp_c4_int", int_log[4], 118);
    check_val("bp_c4_frac", frac_log[4], 500);

    // start and input changes during EMIT are ignored
    fd0 = fd_count;
    start_frame(90, 0, 100, -50);
    wait_col("ign", 10);
    start = 1'b1; angle_X = 10'(200); playerX = 13'(5); playerY = 13'(6);
    @(posedge clock); #1;
    start = 1'b0;
    wait_frame_done("ign");
    check_val("ign_count", n_xfer, 160);
    check_val("ign_fd", fd_count - fd0, 1);
    check_val("ign_c159_int", int_log[159], 60);
    check_val("ign_c20_int", int_log[20], 112);
    check_val("ign_px", px_log[159], 100);
    check_val("ign_py", py_log[159], -50);
    repeat (3) @(negedge clock);
    check_val("ign_no_restart", int'(busy), 0);

    // reset mid-frame at column 50
    angle_X = 10'(90); playerX = '0; playerY = '0;
    fd0 = fd_count;
    start_frame(90, 0, 0, 0);
    wait_col("rst", 50);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_val("rst_mid_valid", int'(ray_valid), 0);
    check_val("rst_mid_busy", int'(busy), 0);
    check_val("rst_mid_col", int'(ray_col), 0);
    repeat (5) @(negedge clock);
    check_val("rst_mid_no_fd", fd_count - fd0, 0);
    start_frame(90, 0, 0, 0);
    wait_frame_done("rst_new");
    check_val("rst_new_count", n_xfer, 160);
    check_val("rst_new_c0_int", int_log[0], 120);
    check_val("rst_new_c0_col", col_log[0], 0);
    check_val("rst_new_fd", fd_count - fd0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
